// File: rtl/keypad_pkg.sv
// Shared constants, debounce state encoding and key-map helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 4;
    localparam int COL_W      = $clog2(KEY_COLS);
    localparam int MAP_W      = KEY_ROWS * KEY_COLS;
    localparam int NKEY_W     = $clog2(MAP_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } keyState_e;

    function automatic logic [NKEY_W-1:0] countKeys(input logic [MAP_W-1:0] map);
        logic [NKEY_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAP_W; i++) begin
            n = n + NKEY_W'(map[i]);
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit is set; returns that bit's index.
    function automatic logic [KEY_CODE_W-1:0] firstKey(input logic [MAP_W-1:0] map);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAP_W; i++) begin
            if (map[i]) begin
                idx = KEY_CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_mod_col_scan.sv
// Column scan timing: slot counter, rotating active-low column drive and sample/frame-end strobes.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYC = 50000
) (
    input  logic                CLK,
    input  logic                RST_n,
    output logic [KEY_COLS-1:0] Column_Scan_Sig,
    output logic [COL_W-1:0]    colIdx_o,
    output logic                sampleStb_o,
    output logic                frameEnd_o
);

    localparam int SLOT_W = $clog2(SCAN_CYC);

    logic [SLOT_W-1:0] slotCnt_q, slotCnt_d;
    logic [COL_W-1:0]  colIdx_q, colIdx_d;
    logic              slotLast;

    assign slotLast = (slotCnt_q == SLOT_W'(SCAN_CYC - 1));

    always_comb begin
        slotCnt_d = slotLast ? '0 : slotCnt_q + SLOT_W'(1);
        colIdx_d  = slotLast ? colIdx_q + COL_W'(1) : colIdx_q;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            slotCnt_q <= '0;
            colIdx_q  <= '0;
        end else begin
            slotCnt_q <= slotCnt_d;
            colIdx_q  <= colIdx_d;
        end
    end

    assign Column_Scan_Sig = ~(KEY_COLS'(1) << colIdx_q);
    assign colIdx_o        = colIdx_q;
    assign sampleStb_o     = slotLast;
    assign frameEnd_o      = slotLast && (colIdx_q == COL_W'(KEY_COLS - 1));

endmodule

// File: rtl/keypad_scan_mod.sv
// 4x4 keypad scanner: synchronises rows, builds a per-frame key map and debounces single-key presses.
module keypad_scan_mod
    import keypad_pkg::*;
#(
    parameter int SCAN_CYC   = 50000,
    parameter int DEB_FRAMES = 5
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [KEY_ROWS-1:0]   Row_In,
    output logic [KEY_COLS-1:0]   Column_Scan_Sig,
    output logic [KEY_CODE_W-1:0] Key_Code,
    output logic                  Key_Valid,
    output logic                  Key_Release,
    output logic                  Key_Down
);

    localparam int CNT_W = $clog2(DEB_FRAMES + 1);

    logic [COL_W-1:0]      colIdx;
    logic                  sampleStb;
    logic                  frameEnd;

    logic [KEY_ROWS-1:0]   rowMeta_q, rowSync_q;
    logic [MAP_W-1:0]      keyMap_q, mapMerged;
    logic [MAP_W-1:0]      frameMap_q;
    logic [NKEY_W-1:0]     frameCount_q;
    logic [KEY_CODE_W-1:0] frameCand_q;
    logic                  frameValid_q;

    keyState_e             state_q, state_d;
    logic [KEY_CODE_W-1:0] stored_q, stored_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KEY_CODE_W-1:0] keyCode_q, keyCode_d;
    logic                  keyValid_q, keyValid_d;
    logic                  keyRelease_q, keyRelease_d;

    logic                  frameSingle, frameMatch, storedPresent, cntLast;

    keypad_col_scan #(
        .SCAN_CYC (SCAN_CYC)
    ) u_col_scan (
        .CLK             (CLK),
        .RST_n           (RST_n),
        .Column_Scan_Sig (Column_Scan_Sig),
        .colIdx_o        (colIdx),
        .sampleStb_o     (sampleStb),
        .frameEnd_o      (frameEnd)
    );

    // Rows idle high, so the synchroniser resets to "nothing pressed".
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rowMeta_q <= '1;
            rowSync_q <= '1;
        end else begin
            rowMeta_q <= Row_In;
            rowSync_q <= rowMeta_q;
        end
    end

    always_comb begin
        mapMerged = keyMap_q;
        for (int r = 0; r < KEY_ROWS; r++) begin
            mapMerged[r * KEY_COLS + int'(colIdx)] = ~rowSync_q[r];
        end
    end

    // The frame result includes the column sampled on the frame-end edge itself.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            keyMap_q     <= '0;
            frameMap_q   <= '0;
            frameCount_q <= '0;
            frameCand_q  <= '0;
            frameValid_q <= 1'b0;
        end else begin
            frameValid_q <= frameEnd;
            if (frameEnd) begin
                keyMap_q     <= '0;
                frameMap_q   <= mapMerged;
                frameCount_q <= countKeys(mapMerged);
                frameCand_q  <= firstKey(mapMerged);
            end else if (sampleStb) begin
                keyMap_q <= mapMerged;
            end
        end
    end

    assign frameSingle   = (frameCount_q == NKEY_W'(1));
    assign frameMatch    = frameSingle && (frameCand_q == stored_q);
    assign storedPresent = frameMap_q[stored_q];
    assign cntLast       = (cnt_q == CNT_W'(DEB_FRAMES - 1));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= ST_IDLE;
            stored_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            stored_q <= stored_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stored_d = stored_q;
        cnt_d    = cnt_q;
        if (frameValid_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (frameSingle) begin
                        state_d  = ST_CONFIRM;
                        stored_d = frameCand_q;
                        cnt_d    = CNT_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (frameMatch) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cntLast) begin
                            state_d = ST_HELD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!storedPresent) begin
                        state_d = ST_RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!storedPresent) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cntLast) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Strobes are registered alongside Key_Code so a consumer sees the new code with Key_Valid.
    always_comb begin
        keyValid_d   = 1'b0;
        keyRelease_d = 1'b0;
        keyCode_d    = keyCode_q;
        if (frameValid_q && (state_q == ST_CONFIRM) && frameMatch && cntLast) begin
            keyValid_d = 1'b1;
            keyCode_d  = stored_q;
        end
        if (frameValid_q && (state_q == ST_RELEASE) && !storedPresent && cntLast) begin
            keyRelease_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            keyCode_q    <= '0;
            keyValid_q   <= 1'b0;
            keyRelease_q <= 1'b0;
        end else begin
            keyCode_q    <= keyCode_d;
            keyValid_q   <= keyValid_d;
            keyRelease_q <= keyRelease_d;
        end
    end

    assign Key_Code    = keyCode_q;
    assign Key_Valid   = keyValid_q;
    assign Key_Release = keyRelease_q;
    assign Key_Down    = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan_mod.sv
// Self-checking bench for keypad_scan_mod: frame-level keypad model, directed cases and random key patterns.
module tb_keypad_scan_mod;

    localparam int SCAN = 4;
    localparam int DEB  = 3;
    localparam int FRAME = SCAN * 4;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [3:0]  Row_In;
    logic [3:0]  Column_Scan_Sig;
    logic [3:0]  Key_Code;
    logic        Key_Valid, Key_Release, Key_Down;

    logic [15:0] keys = 16'h0;
    int          edgeCnt;
    int          checks = 0;
    int          errors = 0;
    int          validSeen = 0;
    int          releaseSeen = 0;

    int          phase, mStored, mCnt;
    int          expCode, expDown, expV, expR;
    logic [15:0] frameKeys;
    logic [3:0]  colExp;

    keypad_scan_mod #(
        .SCAN_CYC   (SCAN),
        .DEB_FRAMES (DEB)
    ) dut (
        .CLK             (CLK),
        .RST_n           (RST_n),
        .Row_In          (Row_In),
        .Column_Scan_Sig (Column_Scan_Sig),
        .Key_Code        (Key_Code),
        .Key_Valid       (Key_Valid),
        .Key_Release     (Key_Release),
        .Key_Down        (Key_Down)
    );

    always #5 CLK = ~CLK;

    // Passive matrix: a row is pulled low when a closed key sits in the driven column.
    always_comb begin
        Row_In = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r * 4 + c] && !Column_Scan_Sig[c]) begin
                    Row_In[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) edgeCnt <= 0;
        else        edgeCnt <= edgeCnt + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Debounce rules applied once per completed frame, given the set of keys held in it.
    task automatic modelFrame(input logic [15:0] s, output int v, output int rl);
        int n;
        int idx;
        n = $countones(s);
        idx = 0;
        for (int i = 0; i < 16; i++) if (s[i]) idx = i;
        v = 0;
        rl = 0;
        case (phase)
            0: if (n == 1) begin phase = 1; mStored = idx; mCnt = 1; end
            1: begin
                if (n == 1 && idx == mStored) begin
                    mCnt++;
                    if (mCnt == DEB) begin
                        phase = 2; expCode = mStored; expDown = 1; v = 1;
                    end
                end else begin
                    phase = 0;
                end
            end
            2: if (!s[mStored]) begin phase = 3; mCnt = 1; end
            default: begin
                if (!s[mStored]) begin
                    mCnt++;
                    if (mCnt == DEB) begin
                        phase = 0; expDown = 0; rl = 1;
                    end
                end else begin
                    phase = 2;
                end
            end
        endcase
    endtask

    // Outputs of a frame ending on edge 16f+15 appear after edge 16f+17 (edge count 16(f+1)+1).
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_n) begin
                phase = 0; mStored = 0; mCnt = 0; expCode = 0; expDown = 0;
            end else begin
                expV = 0;
                expR = 0;
                if (edgeCnt % FRAME == 8) frameKeys = keys;
                if (edgeCnt % FRAME == 1 && edgeCnt > FRAME) modelFrame(frameKeys, expV, expR);
                colExp = 4'hF;
                colExp[(edgeCnt / SCAN) % 4] = 1'b0;
                checkOutput("column", int'(Column_Scan_Sig), int'(colExp));
                checkOutput("valid", int'(Key_Valid), expV);
                checkOutput("release", int'(Key_Release), expR);
                checkOutput("down", int'(Key_Down), expDown);
                checkOutput("code", int'(Key_Code), expCode);
                if (Key_Valid) validSeen++;
                if (Key_Release) releaseSeen++;
            end
        end
    end

    task automatic waitBoundary();
        bit found;
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(posedge CLK);
            #1;
            if (edgeCnt % FRAME == 0) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame boundary: got none expected one within %0d cycles", 2 * FRAME);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input int frames);
        waitBoundary();
        keys = k;
        repeat (frames - 1) waitBoundary();
    endtask

    task automatic settle();
        waitBoundary();
        repeat (2) @(negedge CLK);
    endtask

    int v0, r0, sel, nf;
    logic [15:0] rk;

    initial begin
        RST_n = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset column", int'(Column_Scan_Sig), 4'b1110);
        checkOutput("reset code", int'(Key_Code), 0);
        checkOutput("reset down", int'(Key_Down), 0);
        RST_n = 1'b1;

        $display("[TB] idle scan");
        applyStimulus(16'h0, 2);

        $display("[TB] press key 9");
        v0 = validSeen;
        applyStimulus(16'h0200, 6);
        settle();
        checkOutput("press count", validSeen - v0, 1);
        checkOutput("press code", int'(Key_Code), 9);
        checkOutput("press down", int'(Key_Down), 1);

        $display("[TB] release with bounce");
        r0 = releaseSeen;
        applyStimulus(16'h0000, 1);
        applyStimulus(16'h0200, 1);
        applyStimulus(16'h0000, 3);
        settle();
        checkOutput("release count", releaseSeen - r0, 1);
        checkOutput("release down", int'(Key_Down), 0);
        checkOutput("release code", int'(Key_Code), 9);

        $display("[TB] press bounce");
        v0 = validSeen;
        applyStimulus(16'h0200, 2);
        applyStimulus(16'h0000, 1);
        applyStimulus(16'h0200, 2);
        applyStimulus(16'h0000, 1);
        settle();
        checkOutput("bounce count", validSeen - v0, 0);
        checkOutput("bounce down", int'(Key_Down), 0);

        $display("[TB] two keys");
        applyStimulus(16'h0208, 6);
        settle();
        checkOutput("multi count", validSeen - v0, 0);
        checkOutput("multi code", int'(Key_Code), 9);

        $display("[TB] reset mid-confirm");
        applyStimulus(16'h0000, 1);
        applyStimulus(16'h0200, 2);
        settle();
        #2;
        RST_n = 1'b0;
        #1;
        checkOutput("async column", int'(Column_Scan_Sig), 4'b1110);
        checkOutput("async code", int'(Key_Code), 0);
        checkOutput("async down", int'(Key_Down), 0);
        checkOutput("async valid", int'(Key_Valid), 0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        v0 = validSeen;
        applyStimulus(16'h0200, 1);
        settle();
        checkOutput("post-reset early", validSeen - v0, 0);
        settle();
        checkOutput("post-reset press", validSeen - v0, 1);
        checkOutput("post-reset code", int'(Key_Code), 9);

        $display("[TB] random patterns");
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 9));
            nf  = int'($urandom_range(1, 4));
            rk  = 16'h0;
            if (sel >= 2 && sel <= 7) begin
                case ($urandom_range(0, 3))
                    0: rk[9] = 1'b1;
                    1: rk[5] = 1'b1;
                    2: rk[0] = 1'b1;
                    default: rk[15] = 1'b1;
                endcase
            end else if (sel >= 8) begin
                rk[$urandom_range(0, 15)] = 1'b1;
                rk[$urandom_range(0, 15)] = 1'b1;
            end
            applyStimulus(rk, nf);
        end
        applyStimulus(16'h0, 4);
        settle();

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_mod.md
Name: keypad_scan_mod

Overview:
Scans a 4x4 passive key matrix and reports debounced key events to the rest of the design. It drives one active-low column at a time and samples the four pulled-up, active-low row lines. It is the input-side counterpart of the display scan path, which drives digit selects and segment rows outward. Output is a 4-bit key code plus press/release strobes, for consumption by the digit/encode logic.

Parameters:
SCAN_CYC, 50000, clock cycles per column slot (1 ms at 50 MHz); must be >= 4.
DEB_FRAMES, 5, consecutive identical full-matrix frames needed to accept a press or release; must be >= 2.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST_n  input  1  asynchronous, active-low reset.
Row_In  input  4  matrix row lines, asynchronous, active-low (0 = key closed in driven column).
Column_Scan_Sig  output  4  column drive, one-hot active-low.
Key_Code  output  4  code of last accepted key, row*4 + col; held after release.
Key_Valid  output  1  one-cycle pulse when a press is accepted.
Key_Release  output  1  one-cycle pulse when release of the held key is accepted.
Key_Down  output  1  level, high from press acceptance to release acceptance.

Behaviour:
- Reset (async, immediate): Column_Scan_Sig=4'b1110, slot/column/debounce counters 0, key map cleared, FSM=IDLE, Key_Code=0, Key_Valid=0, Key_Release=0, Key_Down=0. Reset mid-operation aborts any pending press/release; no strobe is emitted.
- Row_In passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Slot counter runs 0..SCAN_CYC-1. On the edge where it equals SCAN_CYC-1:
  - sample the 4 synchronized rows into the 16-bit key map for the current column (bit = row*4+col, 1 = pressed);
  - advance the column 0->1->2->3->0. Column_Scan_Sig = ~(1<<col).
- Frame end is the sample edge of column 3. On that edge, latch the frame result:
  - count = number of pressed bits in the map;
  - cand = index of the single pressed bit when count==1;
  - then clear the map for the next frame.
- Debounce FSM, evaluated on the cycle after the frame-end edge:
  - IDLE: count==1 -> CONFIRM, store cand, deb=1. Otherwise stay.
  - CONFIRM: count==1 and cand==stored -> deb++. When deb reaches DEB_FRAMES: go to HELD, Key_Code<=stored, Key_Valid=1 for one cycle, Key_Down=1. Any other frame -> IDLE, no output change.
  - HELD: stored bit pressed (other keys ignored) -> stay. Stored bit absent -> RELEASE, rel=1.
  - RELEASE: stored bit absent -> rel++. When rel reaches DEB_FRAMES: go to IDLE, Key_Release=1 for one cycle, Key_Down=0. Stored bit present -> HELD.
- Multi-key frames (count>=2) never start or confirm a press.
- Key_Valid and Key_Release are never high in the same cycle. Each is at most one pulse per frame.
- Press latency: strobe in the cycle after the DEB_FRAMES-th matching frame-end edge. With 2-flop sync, a row change must precede the sample edge by >= 2 cycles to be seen.
- Counter widths: $clog2(SCAN_CYC) for the slot counter; $clog2(DEB_FRAMES+1) for deb/rel.

Decomposition:
- Package keypad_pkg:
  - KEY_ROWS=4, KEY_COLS=4, KEY_CODE_W=4;
  - FSM state encoding (IDLE, CONFIRM, HELD, RELEASE).
- Sub-module keypad_col_scan: slot counter, column counter, Column_Scan_Sig drive, sample strobe and frame-end strobe, with ports CLK/RST_n. Debounce FSM and key map stay in the top.

Test Plan:
Bench settings: SCAN_CYC=4, DEB_FRAMES=3, so one frame = 16 cycles. Keypad model: Row_In[r]=0 iff key(r,c) is pressed and Column_Scan_Sig[c]==0.
1. Reset, no keys -> Column_Scan_Sig steps 1110,1101,1011,0111, 4 cycles each, repeating; all key outputs stay 0.
2. Press key (row2,col1), hold 6 frames -> exactly one Key_Valid, in the cycle after the 3rd frame end; Key_Code=9, Key_Down=1 thereafter.
3. Key 9 present 2 frames, absent 1, present 2, absent -> no Key_Valid, Key_Down stays 0.
4. Keys 9 and 3 pressed together for 6 frames -> no Key_Valid; Key_Code unchanged.
5. From case 2: release for 1 frame, press 1 frame, then release for 3 frames -> no strobe after the first release; one Key_Release after the 3rd absent frame; Key_Down=0, Key_Code stays 9.
6. RST_n low mid-CONFIRM (after 2 matching frames) -> outputs reset immediately without waiting for a clock edge, no Key_Valid; after release of reset a fresh 3-frame press is required.
